// File: rtl/noc_pkg.sv
// Shared NoC types: flit format, NI injection FSM states and flit builders.
`timescale 1ns/1ps
package noc_pkg;

    localparam int DEST_ADDR_SIZE_X   = 4;
    localparam int DEST_ADDR_SIZE_Y   = 4;
    localparam int MESH_NODE_ID_WIDTH = 12;
    localparam int PAYLOAD_DATA_WIDTH = 32;

    localparam int HEAD_PL_W = MESH_NODE_ID_WIDTH + PAYLOAD_DATA_WIDTH;
    localparam int FLIT_PL_W = DEST_ADDR_SIZE_X + DEST_ADDR_SIZE_Y + HEAD_PL_W;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_label_t;

    typedef struct packed {
        logic [DEST_ADDR_SIZE_X-1:0] x_dest;
        logic [DEST_ADDR_SIZE_Y-1:0] y_dest;
        logic [HEAD_PL_W-1:0]        head_pl;
    } head_fields_t;

    // Head and body/tail flits share one payload field of identical width.
    typedef union packed {
        head_fields_t         head;
        logic [FLIT_PL_W-1:0] bt_pl;
    } flit_payload_t;

    typedef struct packed {
        flit_label_t   label;
        flit_payload_t payload;
    } flit_novc_t;

    typedef enum logic [1:0] {
        NI_IDLE = 2'd0,
        NI_HEAD = 2'd1,
        NI_BODY = 2'd2
    } ni_state_t;

    function automatic flit_novc_t build_head_flit(
        input logic [DEST_ADDR_SIZE_X-1:0]   x,
        input logic [DEST_ADDR_SIZE_Y-1:0]   y,
        input logic [MESH_NODE_ID_WIDTH-1:0] src,
        input logic [PAYLOAD_DATA_WIDTH-1:0] data
    );
        flit_novc_t f;
        f.label                = HEAD;
        f.payload.head.x_dest  = x;
        f.payload.head.y_dest  = y;
        f.payload.head.head_pl = {src, data};
        return f;
    endfunction

    function automatic flit_novc_t build_bt_flit(
        input flit_label_t                   label,
        input logic [PAYLOAD_DATA_WIDTH-1:0] data
    );
        flit_novc_t f;
        f.label         = label;
        f.payload.bt_pl = {{(FLIT_PL_W-PAYLOAD_DATA_WIDTH){1'b0}}, data};
        return f;
    endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// Credit counter for one downstream buffer: starts full, saturates at DEPTH
// and flags a sticky error when a credit arrives with nothing outstanding.
`timescale 1ns/1ps
module noc_credit_counter #(
    parameter int DEPTH = 8,
    localparam int W    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         nonzero,
    output logic         overflow_err
);

    logic [W-1:0] count_q, count_d;
    logic         err_q, err_d;

    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        if (inc && !dec) begin
            if (count_q == W'(DEPTH)) begin
                err_d = 1'b1;
            end else begin
                count_d = count_q + W'(1);
            end
        end else if (dec && !inc && count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= W'(DEPTH);
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign count        = count_q;
    assign nonzero      = (count_q != '0);
    assign overflow_err = err_q;

endmodule

// File: rtl/noc_ni_packetizer.sv
// NI injection stage: turns a descriptor plus payload beats into a
// HEAD/BODY/TAIL (or HEADTAIL) flit stream, credit-flow-controlled.
`timescale 1ns/1ps
module noc_ni_packetizer
    import noc_pkg::*;
#(
    parameter int MAX_BEATS    = 16,
    parameter int BUFFER_DEPTH = 8,
    localparam int BEAT_W      = $clog2(MAX_BEATS + 1),
    localparam int CRED_W      = $clog2(BUFFER_DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [DEST_ADDR_SIZE_X-1:0]   req_x_dest_i,
    input  logic [DEST_ADDR_SIZE_Y-1:0]   req_y_dest_i,
    input  logic [MESH_NODE_ID_WIDTH-1:0] req_src_i,
    input  logic [BEAT_W-1:0]             req_beats_i,
    input  logic                          data_valid_i,
    output logic                          data_ready_o,
    input  logic [PAYLOAD_DATA_WIDTH-1:0] data_i,
    output logic                          flit_valid_o,
    output logic [$bits(flit_novc_t)-1:0] flit_o,
    input  logic                          credit_i,
    output logic                          busy_o,
    output logic [CRED_W-1:0]             credit_cnt_o,
    output logic                          credit_err_o
);

    ni_state_t                     state_q, state_d;
    logic [DEST_ADDR_SIZE_X-1:0]   x_q, x_d;
    logic [DEST_ADDR_SIZE_Y-1:0]   y_q, y_d;
    logic [MESH_NODE_ID_WIDTH-1:0] src_q, src_d;
    logic [BEAT_W-1:0]             beats_q, beats_d;
    logic [BEAT_W-1:0]             idx_q, idx_d;
    flit_novc_t                    flit_q, flit_d;
    logic                          flit_valid_q, flit_valid_d;
    logic                          cred_ok;
    logic                          emit;

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        src_d        = src_q;
        beats_d      = beats_q;
        idx_d        = idx_q;
        flit_d       = flit_q;
        flit_valid_d = 1'b0;
        req_ready_o  = 1'b0;
        data_ready_o = 1'b0;
        emit         = 1'b0;

        case (state_q)
            NI_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    x_d     = req_x_dest_i;
                    y_d     = req_y_dest_i;
                    src_d   = req_src_i;
                    beats_d = (req_beats_i == '0) ? BEAT_W'(1) : req_beats_i;
                    idx_d   = '0;
                    state_d = NI_HEAD;
                end
            end
            NI_HEAD: begin
                data_ready_o = cred_ok;
                if (data_valid_i && cred_ok) begin
                    emit         = 1'b1;
                    flit_valid_d = 1'b1;
                    flit_d       = build_head_flit(x_q, y_q, src_q, data_i);
                    if (beats_q == BEAT_W'(1)) begin
                        flit_d.label = HEADTAIL;
                        state_d      = NI_IDLE;
                    end else begin
                        state_d = NI_BODY;
                    end
                end
            end
            NI_BODY: begin
                data_ready_o = cred_ok;
                if (data_valid_i && cred_ok) begin
                    emit         = 1'b1;
                    flit_valid_d = 1'b1;
                    idx_d        = idx_q + BEAT_W'(1);
                    // idx counts body beats already sent; the head was beat 0.
                    if ((idx_q + BEAT_W'(1)) == (beats_q - BEAT_W'(1))) begin
                        flit_d  = build_bt_flit(TAIL, data_i);
                        state_d = NI_IDLE;
                    end else begin
                        flit_d = build_bt_flit(BODY, data_i);
                    end
                end
            end
            default: state_d = NI_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= NI_IDLE;
            beats_q      <= '0;
            idx_q        <= '0;
            flit_q       <= '0;
            flit_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            beats_q      <= beats_d;
            idx_q        <= idx_d;
            flit_q       <= flit_d;
            flit_valid_q <= flit_valid_d;
        end
    end

    // Descriptor fields are only read after a handshake, so they skip reset.
    always_ff @(posedge clk) begin
        x_q   <= x_d;
        y_q   <= y_d;
        src_q <= src_d;
    end

    noc_credit_counter #(
        .DEPTH(BUFFER_DEPTH)
    ) u_credit (
        .clk         (clk),
        .rst_n       (rst_n),
        .inc         (credit_i),
        .dec         (emit),
        .count       (credit_cnt_o),
        .nonzero     (cred_ok),
        .overflow_err(credit_err_o)
    );

    assign busy_o       = (state_q != NI_IDLE);
    assign flit_o       = flit_q;
    assign flit_valid_o = flit_valid_q;

endmodule

// File: doc/noc_ni_packetizer.md
# noc_ni_packetizer

Network-interface injection stage between a local agent (aggregation core, aggregation manager or buffer manager) and the LOCAL input port of its mesh router. Accepts a message descriptor (destination, source ID, beat count) plus a stream of PAYLOAD_DATA_WIDTH-bit data beats. Emits one noc_pkg::flit_novc_t per beat: HEAD/BODY/TAIL, or HEADTAIL for single-beat messages. Flow control toward the router is credit-based.

## Interface
Parameters:
- MAX_BEATS, 16, maximum beats per message; BEAT_W = $clog2(MAX_BEATS+1)
- BUFFER_DEPTH, 8, depth of the router LOCAL input buffer, which is also the initial credit count; CRED_W = $clog2(BUFFER_DEPTH+1)

Ports:
- clk  in  1  clock; one clock domain
- rst_n  in  1  reset, synchronous, active-low
- req_valid_i  in  1  descriptor valid
- req_ready_o  out  1  descriptor accepted when both valid and ready are high
- req_x_dest_i  in  DEST_ADDR_SIZE_X  destination column
- req_y_dest_i  in  DEST_ADDR_SIZE_Y  destination row
- req_src_i  in  MESH_NODE_ID_WIDTH  source node ID
- req_beats_i  in  BEAT_W  beat count, 1..MAX_BEATS
- data_valid_i  in  1  payload beat valid
- data_ready_o  out  1  payload beat accepted when both valid and ready are high
- data_i  in  PAYLOAD_DATA_WIDTH  payload beat
- flit_valid_o  out  1  single-cycle pulse; flit_o is valid
- flit_o  out  $bits(flit_novc_t)  outgoing flit
- credit_i  in  1  pulse; the router freed one LOCAL buffer slot
- busy_o  out  1  a message is in progress
- credit_cnt_o  out  CRED_W  current credit count
- credit_err_o  out  1  sticky; a credit was returned while the count was already at BUFFER_DEPTH

## Operation
- FSM states:
  - IDLE: req_ready_o=1. On descriptor handshake, latch dest, src and beats (0 is treated as 1), clear beat_idx, go to HEAD.
  - HEAD: data_ready_o = (credit_cnt>0). On data handshake:
    - Register a flit with x_dest, y_dest and head_pl = {src, data_i} (src in the top MESH_NODE_ID_WIDTH bits, data in the low bits).
    - Label is HEADTAIL if beats==1, then go to IDLE. Otherwise label is HEAD and go to BODY.
  - BODY: data_ready_o = (credit_cnt>0). On data handshake:
    - Register bt_pl = zero-extended data_i.
    - Label is TAIL when beat_idx+1 == beats-1, then go to IDLE. Otherwise label is BODY.
- Credits:
  - The counter decrements on every flit emission and increments on credit_i.
  - Both in the same cycle leaves the count unchanged.
  - credit_i at BUFFER_DEPTH with no emission saturates the count and sets credit_err_o.
  - An emission at count 0 is impossible by construction (data_ready_o is gated by credit_cnt>0).
- busy_o = (state != IDLE).
- No descriptor is accepted while busy. Messages never interleave.

## Timing
- Reset values:
  - state IDLE; req_ready_o=1.
  - data_ready_o, flit_valid_o, busy_o, credit_err_o = 0.
  - flit_o all zero.
  - credit_cnt_o = BUFFER_DEPTH.
- Latency: data handshake in cycle T gives flit_valid_o=1 in cycle T+1, with flit_o held until the next emission.
- Throughput: one flit per cycle while credits > 0 and data_valid_i stays high.
- A descriptor handshake in cycle T allows the first data handshake at T+1 at the earliest.
- The tail flit's handshake at T returns to IDLE, so the next descriptor can be accepted at T+1.
- credit_cnt_o is registered. A credit_i at T is reflected at T+1 and can enable data_ready_o at T+1.
- Reset asserted mid-message takes effect at the next edge:
  - The partial packet is abandoned.
  - All outputs return to their reset values and credits reload to BUFFER_DEPTH.
  - The router side must be reset together with this block.

## Structure
- Add to noc_pkg:
  - ni_state_t enum {NI_IDLE, NI_HEAD, NI_BODY}.
  - Function build_head_flit(x, y, src, data) returning flit_novc_t.
  - Function build_bt_flit(label, data) returning flit_novc_t.
- Sub-module noc_credit_counter (params DEPTH; ports inc, dec, count, nonzero, overflow_err). It is reusable at every router output port.

## Test plan
- Single beat: dest (3,5), src 0x0A1, data 0xDEAD -> one HEADTAIL flit.
  - x_dest=3, y_dest=5.
  - head_pl top bits = 0x0A1, low bits = 0xDEAD.
  - credit_cnt_o goes 8→7.
- 4-beat message, data_valid_i held high, credits 8 -> HEAD, BODY, BODY, TAIL on 4 consecutive cycles.
  - credit_cnt_o ends at 4.
  - busy_o drops the cycle after the tail handshake.
- 10-beat message, BUFFER_DEPTH=8, no credit_i -> exactly 8 flits, then data_ready_o=0.
  - Two credit_i pulses -> the remaining 2 flits, last labelled TAIL.
- credit_i coincident with an emission -> credit_cnt_o unchanged.
  - credit_i at count 8 -> count stays 8 and credit_err_o=1 until reset.
- rst_n low for one cycle after the 2nd flit of a 5-beat message:
  - Next cycle: busy_o=0, credit_cnt_o=8, flit_valid_o=0.
  - A new descriptor is accepted immediately.
- req_beats_i=0 -> treated as 1; the single flit carries label HEADTAIL.
